// File: rtl/chip8_ram_arbiter.sv
// chip8_ram_arbiter
// Shares the single-port CHIP-8 program/sprite RAM between the CPU, the
// blitter and the host loader. The loader has strict priority; CPU and
// blitter alternate through a round-robin pointer. Read data returns on a
// shared registered bus with a per-requester valid pulse.
//
// Optional feature macro: RAM_ARB_LOADER_EN
//   defined   : loader port takes part in arbitration with top priority.
//   undefined : loader inputs are ignored, ldr_ack/ldr_rvalid are tied 0,
//               arbitration is CPU/blitter round-robin only.
//
// Handshake (all three requesters): a requester raises req with wr/addr/wdata
// and holds them stable until it sees ack. ack pulses for one cycle in the
// cycle the access is driven onto the RAM port. A requester whose ack is high
// this cycle is not eligible at the next edge, so a held req cannot be served
// twice for one access. Dropping req before ack withdraws it cleanly. For a
// read issued in cycle N, rvalid pulses with rdata in cycle N+RD_LAT+1.
//
// RD_LAT must be 1 or 2.
module chip8_ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  input  logic              blt_req,
  input  logic              blt_wr,
  input  logic [ADDR_W-1:0] blt_addr,
  input  logic [DATA_W-1:0] blt_wdata,
  output logic              blt_ack,
  output logic              blt_rvalid,
  input  logic              ldr_req,
  input  logic              ldr_wr,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy
);

  // Owner pipeline depth: one stage per cycle from issue to data capture.
  localparam int PIPE_D = RD_LAT + 1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_BLT  = 2'd2,
    OWN_LDR  = 2'd3
  } owner_e;

  // Registered handshake and RAM-port state
  logic              r_cpu_ack;
  logic              r_blt_ack;
  logic              r_cpu_rvalid;
  logic              r_blt_rvalid;
  logic              r_rr_blt;     // 0: pointer at CPU, 1: pointer at blitter
  logic              r_ram_en;
  logic              r_ram_wr;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_in;
  logic [DATA_W-1:0] r_rdata;

  // Read-owner pipeline: stage k holds the read issued k cycles ago
  logic [PIPE_D-1:0]       r_pipe_vld;
  logic [PIPE_D-1:0][1:0]  r_pipe_own;

  // Arbitration results
  owner_e            w_win;
  logic              w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_cpu_elig;
  logic              w_blt_elig;
  logic              w_rd_issue;

`ifdef RAM_ARB_LOADER_EN
  logic              r_ldr_ack;
  logic              r_ldr_rvalid;
`else
  logic              w_unused_ldr;
`endif

  assign w_cpu_elig = cpu_req & ~r_cpu_ack;
  assign w_blt_elig = blt_req & ~r_blt_ack;
  assign w_rd_issue = (w_win != OWN_NONE) & ~w_wr;

  // Pick this edge's winner and mux its access; idle keeps address/data
  always_comb begin
    w_win   = OWN_NONE;
    w_wr    = 1'b0;
    w_addr  = r_ram_addr;
    w_wdata = r_ram_in;
    if (w_cpu_elig && (!r_rr_blt || !w_blt_elig)) begin
      w_win = OWN_CPU;
    end else if (w_blt_elig) begin
      w_win = OWN_BLT;
    end
`ifdef RAM_ARB_LOADER_EN
    if (ldr_req && !r_ldr_ack) begin
      w_win = OWN_LDR;
    end
`endif
    case (w_win)
      OWN_CPU: begin
        w_wr    = cpu_wr;
        w_addr  = cpu_addr;
        w_wdata = cpu_wdata;
      end
      OWN_BLT: begin
        w_wr    = blt_wr;
        w_addr  = blt_addr;
        w_wdata = blt_wdata;
      end
`ifdef RAM_ARB_LOADER_EN
      OWN_LDR: begin
        w_wr    = ldr_wr;
        w_addr  = ldr_addr;
        w_wdata = ldr_wdata;
      end
`endif
      default: ;
    endcase
  end

  // Issue the winning access to the RAM port and pulse its ack
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_cpu_ack  <= 1'b0;
      r_blt_ack  <= 1'b0;
      r_ram_en   <= 1'b0;
      r_ram_wr   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_in   <= '0;
    end else begin
      r_cpu_ack  <= (w_win == OWN_CPU);
      r_blt_ack  <= (w_win == OWN_BLT);
      r_ram_en   <= (w_win != OWN_NONE);
      r_ram_wr   <= w_wr;
      r_ram_addr <= w_addr;
      r_ram_in   <= w_wdata;
    end
  end

  // Round-robin pointer moves to the loser of each CPU/blitter grant
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_rr_blt <= 1'b0;
    end else if (w_win == OWN_CPU) begin
      r_rr_blt <= 1'b1;
    end else if (w_win == OWN_BLT) begin
      r_rr_blt <= 1'b0;
    end
  end

  // Carry read ownership alongside the RAM latency
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_pipe_vld <= '0;
      r_pipe_own <= '0;
    end else begin
      r_pipe_vld <= {r_pipe_vld[PIPE_D-2:0], w_rd_issue};
      r_pipe_own <= {r_pipe_own[PIPE_D-2:0], w_win};
    end
  end

  // Capture read data and pulse the owner's rvalid
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_rdata      <= '0;
      r_cpu_rvalid <= 1'b0;
      r_blt_rvalid <= 1'b0;
    end else begin
      if (r_pipe_vld[RD_LAT]) begin
        r_rdata <= ram_out;
      end
      r_cpu_rvalid <= r_pipe_vld[RD_LAT] && (r_pipe_own[RD_LAT] == OWN_CPU);
      r_blt_rvalid <= r_pipe_vld[RD_LAT] && (r_pipe_own[RD_LAT] == OWN_BLT);
    end
  end

`ifdef RAM_ARB_LOADER_EN
  // Loader handshake registers
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_ldr_ack    <= 1'b0;
      r_ldr_rvalid <= 1'b0;
    end else begin
      r_ldr_ack    <= (w_win == OWN_LDR);
      r_ldr_rvalid <= r_pipe_vld[RD_LAT] && (r_pipe_own[RD_LAT] == OWN_LDR);
    end
  end

  assign ldr_ack    = r_ldr_ack;
  assign ldr_rvalid = r_ldr_rvalid;
`else
  // Loader port kept for a stable top level; its inputs go nowhere
  assign w_unused_ldr = ^{ldr_req, ldr_wr, ldr_addr, ldr_wdata};
  assign ldr_ack      = 1'b0;
  assign ldr_rvalid   = 1'b0;
`endif

  assign cpu_ack    = r_cpu_ack;
  assign blt_ack    = r_blt_ack;
  assign cpu_rvalid = r_cpu_rvalid;
  assign blt_rvalid = r_blt_rvalid;
  assign rdata      = r_rdata;
  assign ram_en     = r_ram_en;
  assign ram_wr     = r_ram_wr;
  assign ram_addr   = r_ram_addr;
  assign ram_in     = r_ram_in;
  assign busy       = r_ram_en | (|r_pipe_vld);

endmodule

// File: tb/tb_chip8_ram_arbiter.sv
// tb_chip8_ram_arbiter
// Drives CPU, blitter and (when RAM_ARB_LOADER_EN is defined) loader accesses
// into chip8_ram_arbiter backed by a behavioural RAM. A reference memory image
// is updated in grant order; each granted read pushes its expected owner, data
// and return cycle into exp_q, and a monitor pops and compares on every rvalid.
module tb_chip8_ram_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 1;
  localparam int W      = 32 + 2 + DATA_W;
  localparam int ACK_TO = 60;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic res;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic              cpu_req, cpu_wr, blt_req, blt_wr, ldr_req, ldr_wr;
  logic [ADDR_W-1:0] cpu_addr, blt_addr, ldr_addr;
  logic [DATA_W-1:0] cpu_wdata, blt_wdata, ldr_wdata;
  logic              cpu_ack, cpu_rvalid, blt_ack, blt_rvalid, ldr_ack, ldr_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              ram_en, ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_in, ram_out;
  logic              busy;

  chip8_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .res(res),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
    .blt_req(blt_req), .blt_wr(blt_wr), .blt_addr(blt_addr), .blt_wdata(blt_wdata),
    .blt_ack(blt_ack), .blt_rvalid(blt_rvalid),
    .ldr_req(ldr_req), .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rvalid(ldr_rvalid),
    .rdata(rdata), .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr),
    .ram_in(ram_in), .ram_out(ram_out), .busy(busy)
  );

  // Deterministic power-up contents shared by the RAM and the reference image
  function automatic logic [DATA_W-1:0] init_val(input int i);
    if (i == 'h180) return 8'h12;
    return 8'((i * 29 + 7) ^ (i >> 4));
  endfunction

  // ---------------- behavioural RAM (RD_LAT cycles) ----------------
  logic [DATA_W-1:0] ram_mem [1 << ADDR_W];
  logic [DATA_W-1:0] ram_d1, ram_d2;
  assign ram_out = (RD_LAT == 1) ? ram_d1 : ram_d2;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram_mem[i] = init_val(i);
    ram_d1 = '0;
    ram_d2 = '0;
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_wr) ram_mem[ram_addr] <= ram_in;
        else        ram_d1 <= ram_mem[ram_addr];
      end
      ram_d2 <= ram_d1;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
  logic [W-1:0]      exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
`ifndef RAM_ARB_LOADER_EN
  int ldr_seen = 0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({cpu_ack, cpu_rvalid, blt_ack, blt_rvalid, ldr_ack, ldr_rvalid,
                rdata, ram_en, ram_wr, ram_addr, ram_in, busy});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int who, input logic rq, input logic wr,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    case (who)
      1: begin cpu_req = rq; if (rq) begin cpu_wr = wr; cpu_addr = a; cpu_wdata = d; end end
      2: begin blt_req = rq; if (rq) begin blt_wr = wr; blt_addr = a; blt_wdata = d; end end
      default: begin ldr_req = rq; if (rq) begin ldr_wr = wr; ldr_addr = a; ldr_wdata = d; end end
    endcase
  endtask

  function automatic logic ack_of(input int who);
    case (who)
      1:       return cpu_ack;
      2:       return blt_ack;
      default: return ldr_ack;
    endcase
  endfunction

  // One access: raise req (caller is just after a rising edge), wait for ack,
  // apply it to the reference image, then release req after the next edge.
  task automatic access(input int who, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, output int ack_cyc);
    int   waited;
    logic got;
    set_req(who, 1'b1, wr, a, d);
    ack_cyc = -1;
    waited  = 0;
    got     = 1'b0;
    while (!got && waited < ACK_TO) begin
      @(negedge clk);
      if (ack_of(who)) begin
        got     = 1'b1;
        ack_cyc = cyc;
      end
      waited++;
    end
    chk("ack_seen", 64'(got), 64'd1);
    if (got) begin
      chk("ram_en_at_ack", 64'(ram_en), 64'd1);
      chk("ram_wr_at_ack", 64'(ram_wr), 64'(wr));
      chk("ram_addr_at_ack", 64'(ram_addr), 64'(a));
      if (wr) begin
        chk("ram_in_at_ack", 64'(ram_in), 64'(d));
        ref_mem[a] = d;
      end else begin
        exp_q.push_back({32'(cyc + RD_LAT + 1), 2'(who), ref_mem[a]});
      end
    end
    @(posedge clk);
    #1;
    set_req(who, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_driver(input int who, input int n_ops);
    int a;
    for (int i = 0; i < n_ops; i++) begin
      idle_cycles($urandom_range(0, 3));
      access(who, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)),
             8'($urandom_range(0, 255)), a);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    logic [W-1:0] e;
    int   n_ack, n_rv, own;
    logic prev_cpu_ack, prev_blt_ack;
`ifdef RAM_ARB_LOADER_EN
    logic prev_ldr_ack, prev_ldr_elig;
    prev_ldr_ack  = 1'b0;
    prev_ldr_elig = 1'b0;
`endif
    prev_cpu_ack = 1'b0;
    prev_blt_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (res) begin
        prev_cpu_ack = 1'b0;
        prev_blt_ack = 1'b0;
`ifdef RAM_ARB_LOADER_EN
        prev_ldr_ack  = 1'b0;
        prev_ldr_elig = 1'b0;
`endif
        continue;
      end
      n_ack = int'(cpu_ack) + int'(blt_ack) + int'(ldr_ack);
      if (n_ack != 0) chk("one_ack_per_cycle", 64'(n_ack), 64'd1);
      if (cpu_ack) chk("cpu_ack_spacing", 64'(prev_cpu_ack), 64'd0);
      if (blt_ack) chk("blt_ack_spacing", 64'(prev_blt_ack), 64'd0);
`ifdef RAM_ARB_LOADER_EN
      if (ldr_ack) chk("ldr_ack_spacing", 64'(prev_ldr_ack), 64'd0);
      if (cpu_ack || blt_ack) chk("ldr_priority", 64'(prev_ldr_elig), 64'd0);
`else
      if (ldr_ack || ldr_rvalid) ldr_seen++;
`endif
      if (ram_en) chk("busy_when_issuing", 64'(busy), 64'd1);
      else if (exp_q.size() == 0) chk("idle_not_busy", 64'(busy), 64'd0);
      else if (int'(exp_q[0][W-1:W-32]) > cyc) chk("busy_read_in_flight", 64'(busy), 64'd1);

      n_rv = int'(cpu_rvalid) + int'(blt_rvalid) + int'(ldr_rvalid);
      if (n_rv != 0) begin
        chk("one_rvalid_per_cycle", 64'(n_rv), 64'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", 64'(n_rv), 64'd0);
        end else begin
          e   = exp_q.pop_front();
          own = cpu_rvalid ? 1 : (blt_rvalid ? 2 : 3);
          chk("rvalid_owner", 64'(own), 64'(e[DATA_W+1:DATA_W]));
          chk("rvalid_cycle", 64'(cyc), 64'(e[W-1:W-32]));
          chk("rdata", 64'(rdata), 64'(e[DATA_W-1:0]));
        end
      end else if (exp_q.size() != 0 && int'(exp_q[0][W-1:W-32]) < cyc) begin
        e = exp_q.pop_front();
        chk("missing_rvalid", 64'(cyc), 64'(e[W-1:W-32]));
      end
      prev_cpu_ack = cpu_ack;
      prev_blt_ack = blt_ack;
`ifdef RAM_ARB_LOADER_EN
      prev_ldr_ack  = ldr_ack;
      prev_ldr_elig = ldr_req & ~ldr_ack;
`endif
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int s, a_c, a_b, a_l, rv_seen;
    logic [DATA_W-1:0] v;

    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = init_val(i);
    res = 1'b1;
    cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    blt_req = 0; blt_wr = 0; blt_addr = '0; blt_wdata = '0;
    ldr_req = 0; ldr_wr = 0; ldr_addr = '0; ldr_wdata = '0;

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", out_vec(), 64'd0);
    res = 1'b0;

    // CPU and blitter together right after reset: CPU first, then blitter
    s = cyc;
    fork
      access(1, 1'b0, 12'h200, 8'h00, a_c);
      access(2, 1'b0, 12'h300, 8'h00, a_b);
    join
    chk("pair_cpu_ack_cycle", 64'(a_c), 64'(s + 1));
    chk("pair_blt_ack_cycle", 64'(a_b), 64'(s + 2));

    // Continuous CPU + blitter requests: strict alternation, 10 grants each
    s = cyc;
    fork
      for (int i = 0; i < 10; i++) begin
        int a;
        access(1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), a);
        chk("alt_cpu_grant", 64'(a), 64'(s + 1 + 2 * i));
      end
      for (int j = 0; j < 10; j++) begin
        int b;
        access(2, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), b);
        chk("alt_blt_grant", 64'(b), 64'(s + 2 + 2 * j));
      end
    join

    // Single CPU read of the preloaded 0x12 at 0x180
    s = cyc;
    access(1, 1'b0, 12'h180, 8'h00, a_c);
    chk("single_cpu_ack_cycle", 64'(a_c), 64'(s + 1));
    @(posedge clk);
    @(negedge clk);
    chk("single_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    chk("single_cpu_rdata", 64'(rdata), 64'h12);
    @(posedge clk);
    #1;

    // Loader against continuous CPU/blitter traffic (pointer now at blitter)
    s = cyc;
`ifdef RAM_ARB_LOADER_EN
    fork
      access(3, 1'b1, 12'h050, 8'hAB, a_l);
      access(1, 1'b0, 12'h0A0, 8'h00, a_c);
      access(2, 1'b0, 12'h0B0, 8'h00, a_b);
    join
    chk("ldr_first_ack", 64'(a_l), 64'(s + 1));
    chk("ldr_then_blt", 64'(a_b), 64'(s + 2));
    chk("ldr_then_cpu", 64'(a_c), 64'(s + 3));
    access(1, 1'b0, 12'h050, 8'h00, a_c);
`else
    a_l = 0;
    set_req(3, 1'b1, 1'b1, 12'h050, 8'hAB);
    fork
      access(1, 1'b0, 12'h0A0, 8'h00, a_c);
      access(2, 1'b0, 12'h0B0, 8'h00, a_b);
    join
    chk("noldr_blt_ack", 64'(a_b), 64'(s + 1));
    chk("noldr_cpu_ack", 64'(a_c), 64'(s + 2));
    access(1, 1'b0, 12'h050, 8'h00, a_c);
    set_req(3, 1'b0, 1'b0, '0, '0);
`endif
    idle_cycles(4);

    // Reset one cycle after a CPU read issue: outputs clear at once, no rvalid later
    access(1, 1'b0, 12'h123, 8'h00, a_c);
    res = 1'b1;
    #1;
    chk("async_reset_outputs", out_vec(), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    res = 1'b0;
    rv_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_rvalid) rv_seen++;
    end
    chk("no_rvalid_after_reset", 64'(rv_seen), 64'd0);
    @(posedge clk);
    #1;

    // Randomised mixed traffic checked by the scoreboard
    fork
      rand_driver(1, 25);
      rand_driver(2, 25);
`ifdef RAM_ARB_LOADER_EN
      rand_driver(3, 12);
`endif
    join

    // Drain outstanding reads
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    // Final cross-check on a written location through the RAM model
    v = ref_mem[12'h050];
    chk("ram_image_0x050", 64'(ram_mem[12'h050]), 64'(v));
`ifndef RAM_ARB_LOADER_EN
    chk("ldr_never_acks", 64'(ldr_seen), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
